// File: rtl/legv8_pkg.sv
// legv8_pkg: shared widths, register constants and MEM-stage types
// for the LEGv8 pipeline.
package legv8_pkg;

    // Datapath and register index widths (same values as common.vh)
    localparam int WORD       = 64;
    localparam int REG_ADDR_W = 5;

    // Zero register; its write suppression lives in the register file
    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    // Data-memory access state
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Any data-memory instruction
    function automatic logic is_mem_op(input logic rd_op, input logic wr_op);
        return rd_op | wr_op;
    endfunction

    // Doubleword accesses must sit on an 8-byte boundary
    function automatic logic is_misaligned(input logic [2:0] low_bits);
        return low_bits != 3'b000;
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request FSM, timeout counter and held request
// registers for the MEM stage data-memory port.
module mem_req_ctrl
    import legv8_pkg::*;
#(
    parameter int WORD_W      = WORD,
    parameter int REG_ADDR_W  = legv8_pkg::REG_ADDR_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_W-1:0]     start_addr,
    input  logic [WORD_W-1:0]     start_wdata,
    input  logic                  start_we,
    input  logic [REG_ADDR_W-1:0] start_rd,
    input  logic                  start_reg_write,
    input  logic                  start_mem_to_reg,
    input  logic                  dmem_ack,
    output logic                  busy,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    output logic                  dmem_err,
    output logic                  ack_done,
    output logic                  timeout_done,
    output logic [REG_ADDR_W-1:0] hold_rd,
    output logic                  hold_reg_write,
    output logic                  hold_mem_to_reg
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    assign busy     = (state == BUSY);
    assign dmem_req = busy;

    // cnt counts the ack-less BUSY cycles already completed, so the
    // cycle that would take it to TIMEOUT_CYC is the final one
    assign cnt_last     = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign ack_done     = busy & dmem_ack;
    assign timeout_done = busy & ~dmem_ack & cnt_last;

    // Request FSM: latch on start, hold until ack or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_err        <= 1'b0;
            hold_rd         <= '0;
            hold_reg_write  <= 1'b0;
            hold_mem_to_reg <= 1'b0;
        end else begin
            dmem_err <= timeout_done;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state           <= BUSY;
                        cnt             <= '0;
                        dmem_we         <= start_we;
                        dmem_addr       <= start_addr;
                        dmem_wdata      <= start_wdata;
                        hold_rd         <= start_rd;
                        hold_reg_write  <= start_reg_write;
                        hold_mem_to_reg <= start_mem_to_reg;
                    end
                end
                BUSY: begin
                    if (ack_done || timeout_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: LEGv8 MEM stage, multi-cycle data memory with stall.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_stage
    import legv8_pkg::*;
#(
    parameter int WORD_W      = WORD,
    parameter int REG_ADDR_W  = legv8_pkg::REG_ADDR_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WORD_W-1:0]     in_ALUOut,
    input  logic [WORD_W-1:0]     in_w_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_MemRead,
    input  logic                  in_MemWrite,
    input  logic                  in_RegWrite,
    input  logic                  in_MemtoReg,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic [WORD_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  dmem_err,
    output logic                  align_err,
    output logic                  wb_valid,
    output logic [WORD_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_RegWrite
);

    logic                  busy;
    logic                  accept;
    logic                  mem_op;
    logic                  misaligned;
    logic                  start;
    logic                  pass_fire;
    logic                  mis_fire;
    logic                  ack_done;
    logic                  timeout_done;
    logic [REG_ADDR_W-1:0] hold_rd;
    logic                  hold_reg_write;
    logic                  hold_mem_to_reg;

    assign stall  = busy;
    assign accept = in_valid & ~busy;
    assign mem_op = is_mem_op(in_MemRead, in_MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & is_misaligned(in_ALUOut[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign start     = accept & mem_op & ~misaligned;
    assign pass_fire = accept & ~mem_op;
    assign mis_fire  = accept & misaligned;

    mem_req_ctrl #(
        .WORD_W      (WORD_W),
        .REG_ADDR_W  (REG_ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_req_ctrl (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .start_addr       (in_ALUOut),
        .start_wdata      (in_w_data),
        .start_we         (in_MemWrite),
        .start_rd         (in_rd),
        .start_reg_write  (in_RegWrite),
        .start_mem_to_reg (in_MemtoReg),
        .dmem_ack         (dmem_ack),
        .busy             (busy),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_err         (dmem_err),
        .ack_done         (ack_done),
        .timeout_done     (timeout_done),
        .hold_rd          (hold_rd),
        .hold_reg_write   (hold_reg_write),
        .hold_mem_to_reg  (hold_mem_to_reg)
    );

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle pulse for a rejected misaligned access
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err <= 1'b0;
        end else begin
            align_err <= mis_fire;
        end
    end
`else
    assign align_err = 1'b0;
`endif

    // Write-back register: one pulse per retired instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_RegWrite <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (1'b1)
                ack_done: begin
                    wb_valid    <= 1'b1;
                    wb_data     <= hold_mem_to_reg ? dmem_rdata : dmem_addr;
                    wb_rd       <= hold_rd;
                    wb_RegWrite <= hold_reg_write & ~dmem_we;
                end
                timeout_done: begin
                    wb_valid    <= 1'b1;
                    wb_data     <= dmem_addr;
                    wb_rd       <= hold_rd;
                    wb_RegWrite <= 1'b0;
                end
                pass_fire: begin
                    wb_valid    <= 1'b1;
                    wb_data     <= in_ALUOut;
                    wb_rd       <= in_rd;
                    wb_RegWrite <= in_RegWrite;
                end
                mis_fire: begin
                    wb_valid    <= 1'b1;
                    wb_data     <= in_ALUOut;
                    wb_rd       <= in_rd;
                    wb_RegWrite <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against
// a transaction-level model of the MEM stage rules.
module tb_mem_stage;

    localparam int W  = 64;
    localparam int RW = 5;
    localparam int TO = 8;

    logic          tb_clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_ALUOut = '0;
    logic [W-1:0]  in_w_data = '0;
    logic [RW-1:0] in_rd = '0;
    logic          in_MemRead = 1'b0;
    logic          in_MemWrite = 1'b0;
    logic          in_RegWrite = 1'b0;
    logic          in_MemtoReg = 1'b0;
    logic          stall;
    logic          dmem_req;
    logic          dmem_we;
    logic [W-1:0]  dmem_addr;
    logic [W-1:0]  dmem_wdata;
    logic [W-1:0]  dmem_rdata = '0;
    logic          dmem_ack = 1'b0;
    logic          dmem_err;
    logic          align_err;
    logic          wb_valid;
    logic [W-1:0]  wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_RegWrite;

    int nchk = 0;
    int nerr = 0;

    always #5 tb_clk = ~tb_clk;

    mem_stage #(
        .WORD_W      (W),
        .REG_ADDR_W  (RW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ALUOut   (in_ALUOut),
        .in_w_data   (in_w_data),
        .in_rd       (in_rd),
        .in_MemRead  (in_MemRead),
        .in_MemWrite (in_MemWrite),
        .in_RegWrite (in_RegWrite),
        .in_MemtoReg (in_MemtoReg),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .dmem_err    (dmem_err),
        .align_err   (align_err),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_RegWrite (wb_RegWrite)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One instruction through the stage; ack_at is the BUSY cycle
    // carrying dmem_ack (0 or > TO means no ack). With follow set, an
    // ADD waits upstream during the access and must retire next.
    task automatic run_op(input logic [W-1:0] alu, input logic [W-1:0] wd,
                          input logic [RW-1:0] rd, input bit rdop,
                          input bit wrop, input bit regw, input bit m2r,
                          input int ack_at, input logic [W-1:0] rdata,
                          input bit follow, input logic [W-1:0] alu2,
                          input logic [RW-1:0] rd2);
        bit mem;
        bit mis;
        bit acked;
        int nbusy;
        mem   = rdop | wrop;
`ifdef MEM_ALIGN_CHECK_EN
        mis   = mem && (alu[2:0] != 3'b000);
`else
        mis   = 1'b0;
`endif
        acked = (ack_at >= 1) && (ack_at <= TO);
        nbusy = acked ? ack_at : TO;

        in_valid    = 1'b1;
        in_ALUOut   = alu;
        in_w_data   = wd;
        in_rd       = rd;
        in_MemRead  = rdop;
        in_MemWrite = wrop;
        in_RegWrite = regw;
        in_MemtoReg = m2r;
        chk("stall_before", stall, 0);
        tick();

        if (!mem || mis) begin
            in_valid = 1'b0;
            chk("imm_wb_valid", wb_valid, 1);
            chk("imm_stall", stall, 0);
            chk("imm_req", dmem_req, 0);
            if (mis) begin
                chk("mis_align_err", align_err, 1);
                chk("mis_regwrite", wb_RegWrite, 0);
            end else begin
                chk("alu_wb_data", wb_data, alu);
                chk("alu_wb_rd", wb_rd, rd);
                chk("alu_regwrite", wb_RegWrite, regw);
                chk("alu_align_err", align_err, 0);
            end
            return;
        end

        if (follow) begin
            in_valid    = 1'b1;
            in_ALUOut   = alu2;
            in_w_data   = rnd64();
            in_rd       = rd2;
            in_MemRead  = 1'b0;
            in_MemWrite = 1'b0;
            in_RegWrite = 1'b1;
            in_MemtoReg = 1'b0;
        end else begin
            in_valid  = 1'b0;
            in_ALUOut = rnd64();
            in_w_data = rnd64();
        end

        for (int k = 1; k <= nbusy; k++) begin
            chk("busy_stall", stall, 1);
            chk("busy_req", dmem_req, 1);
            chk("busy_addr", dmem_addr, alu);
            chk("busy_we", dmem_we, wrop);
            chk("busy_wdata", dmem_wdata, wd);
            chk("busy_wb_valid", wb_valid, 0);
            if (acked && k == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            dmem_ack   = 1'b0;
            dmem_rdata = rnd64();
        end

        chk("done_stall", stall, 0);
        chk("done_req", dmem_req, 0);
        chk("done_wb_valid", wb_valid, 1);
        chk("done_align_err", align_err, 0);
        if (acked) begin
            chk("ack_err", dmem_err, 0);
            chk("ack_wb_data", wb_data, m2r ? rdata : alu);
            chk("ack_wb_rd", wb_rd, rd);
            chk("ack_regwrite", wb_RegWrite, regw & ~wrop);
        end else begin
            chk("to_err", dmem_err, 1);
            chk("to_regwrite", wb_RegWrite, 0);
        end

        if (follow) begin
            tick();
            in_valid = 1'b0;
            chk("next_wb_valid", wb_valid, 1);
            chk("next_wb_data", wb_data, alu2);
            chk("next_wb_rd", wb_rd, rd2);
            chk("next_regwrite", wb_RegWrite, 1);
            chk("next_err", dmem_err, 0);
            chk("next_stall", stall, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        int           kind;

        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_err", dmem_err, 0);
        chk("rst_align", align_err, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_regwrite", wb_RegWrite, 0);
        rst = 1'b0;
        tick();

        // ADD passthrough, then held outputs
        run_op(64'd28, 0, 5'd10, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("hold_wb_valid", wb_valid, 0);
        chk("hold_wb_data", wb_data, 64'd28);
        chk("hold_wb_rd", wb_rd, 5'd10);

        // Stray ack while idle
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("stray_wb_valid", wb_valid, 0);
        chk("stray_stall", stall, 0);
        chk("stray_req", dmem_req, 0);

        // LDUR X9, ack on the 3rd BUSY cycle
        run_op(64'h40, 0, 5'd9, 1, 0, 1, 1, 3, 64'hDEADBEEF, 0, 0, 0);
        // STUR X11, ack on the 1st BUSY cycle
        run_op(64'h60, 0, 5'd11, 0, 1, 1, 0, 1, rnd64(), 0, 0, 0);
        // Load then ADD held upstream
        run_op(64'h80, 0, 5'd3, 1, 0, 1, 1, 2, rnd64(), 1, 64'd5, 5'd12);
        // Timeout, no ack ever
        run_op(64'h100, 0, 5'd4, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        // Ack on the timeout cycle wins
        run_op(64'h108, 0, 5'd6, 1, 0, 1, 1, TO, rnd64(), 0, 0, 0);
        // Read and write together act as a store
        run_op(64'h20, 64'h1234, 5'd7, 1, 1, 1, 0, 2, rnd64(), 0, 0, 0);

        // Reset on the 2nd BUSY cycle
        in_valid    = 1'b1;
        in_ALUOut   = 64'h200;
        in_rd       = 5'd2;
        in_MemRead  = 1'b1;
        in_MemWrite = 1'b0;
        in_RegWrite = 1'b1;
        in_MemtoReg = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rb_req1", dmem_req, 1);
        tick();
        chk("rb_req2", dmem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_req", dmem_req, 0);
        chk("rb_stall", stall, 0);
        chk("rb_wb_valid", wb_valid, 0);
        tick();
        chk("rb_wb_valid2", wb_valid, 0);
        chk("rb_req3", dmem_req, 0);

        // Misaligned load
        run_op(64'h56, 0, 5'd8, 1, 0, 1, 1, 1, rnd64(), 0, 0, 0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a    = rnd64();
            if (kind != 0) a = a & ~64'd7;
            run_op(a, rnd64(), RW'($urandom_range(0, 31)),
                   kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 9),
                   rnd64(), 1'($urandom_range(0, 1)), rnd64(),
                   RW'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
